// File: rtl/fetch_stage_pkg.sv
// pmips_defs: definitions shared by the pMIPS pipeline blocks.
//   INSTR_W     instruction word width.
//   NOP_INSTR   encoding used for bubbles and flushes.
//   FETCH_*     fetch-stage state encoding.
package pmips_defs;

    localparam int INSTR_W = 16;

    localparam logic [0:INSTR_W-1] NOP_INSTR = 16'h0000;

    localparam logic [1:0] FETCH_FILL  = 2'd0;
    localparam logic [1:0] FETCH_RUN   = 2'd1;
    localparam logic [1:0] FETCH_STALL = 2'd2;

endpackage

// File: rtl/fetch_stage_sat_counter.sv
// sat_counter: W-bit up-counter with enable that sticks at all-ones.
// Generic enough to be reused for other performance counters.
//   clk_i    rising-edge clock
//   rst_i    asynchronous active-high reset, clears the count
//   en_i     count this cycle
//   count_o  current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: pMIPS instruction fetch plus IF/ID pipeline register.
// Drives a synchronous-read instruction BRAM and hands instructions to
// decode. stall freezes the PC and IF/ID; branch_taken flushes IF/ID with
// a NOP and redirects fetch (flush wins over stall).
//
// Ports:
//   clock, reset          clock / asynchronous active-high reset
//   stall                 hold PC and IF/ID this cycle
//   branch_taken          taken branch resolved this cycle
//   branch_target         redirect word address
//   imem_addr             registered BRAM read address
//   imem_data             BRAM read data (one cycle after imem_addr)
//   instruc, pc_out       IF/ID instruction and its address (bit 0 = MSB)
//   instr_valid           instruc is a real instruction
//   stall_count           stall-cycle counter
//
// Build option: define STALL_COUNT_EN to enable the saturating stall-cycle
// counter; otherwise stall_count is tied to zero.
module fetch_stage
    import pmips_defs::*;
#(
    parameter int                  ADDR_W    = 8,
    parameter logic [ADDR_W-1:0]   RESET_PC  = '0,
    parameter logic [0:INSTR_W-1]  NOP_INSTR = pmips_defs::NOP_INSTR
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [ADDR_W-1:0]   branch_target,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [0:INSTR_W-1]  imem_data,
    output logic [0:INSTR_W-1]  instruc,
    output logic [ADDR_W-1:0]   pc_out,
    output logic                instr_valid,
    output logic [15:0]         stall_count
);

    logic [1:0]          state_q,     state_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [ADDR_W-1:0]   fetch_pc_q,  fetch_pc_d;
    logic [0:INSTR_W-1]  instruc_q,   instruc_d;
    logic [ADDR_W-1:0]   pc_out_q,    pc_out_d;
    logic                valid_q,     valid_d;
    logic [0:INSTR_W-1]  hold_q,      hold_d;

    always_comb begin
        state_d     = state_q;
        imem_addr_d = imem_addr_q;
        fetch_pc_d  = fetch_pc_q;
        instruc_d   = instruc_q;
        pc_out_d    = pc_out_q;
        valid_d     = valid_q;
        hold_d      = hold_q;

        if (branch_taken) begin
            imem_addr_d = branch_target;
            instruc_d   = NOP_INSTR;
            valid_d     = 1'b0;
            state_d     = FETCH_FILL;
        end else begin
            case (state_q)
                FETCH_FILL: begin
                    // BRAM latency slot: IF/ID already holds a bubble,
                    // so stall has nothing to protect here.
                    fetch_pc_d  = imem_addr_q;
                    imem_addr_d = imem_addr_q + ADDR_W'(1);
                    instruc_d   = NOP_INSTR;
                    valid_d     = 1'b0;
                    state_d     = FETCH_RUN;
                end
                FETCH_RUN: begin
                    if (stall) begin
                        // The BRAM has no read enable, so its output moves
                        // on to imem_addr's word during the stall. Keep the
                        // word belonging to fetch_pc for the release cycle.
                        hold_d  = imem_data;
                        state_d = FETCH_STALL;
                    end else begin
                        instruc_d   = imem_data;
                        pc_out_d    = fetch_pc_q;
                        valid_d     = 1'b1;
                        fetch_pc_d  = imem_addr_q;
                        imem_addr_d = imem_addr_q + ADDR_W'(1);
                    end
                end
                FETCH_STALL: begin
                    if (!stall) begin
                        instruc_d   = hold_q;
                        pc_out_d    = fetch_pc_q;
                        valid_d     = 1'b1;
                        fetch_pc_d  = imem_addr_q;
                        imem_addr_d = imem_addr_q + ADDR_W'(1);
                        state_d     = FETCH_RUN;
                    end
                end
                default: begin
                    state_d = FETCH_FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= FETCH_FILL;
            imem_addr_q <= RESET_PC;
            fetch_pc_q  <= RESET_PC;
            instruc_q   <= NOP_INSTR;
            pc_out_q    <= '0;
            valid_q     <= 1'b0;
            hold_q      <= NOP_INSTR;
        end else begin
            state_q     <= state_d;
            imem_addr_q <= imem_addr_d;
            fetch_pc_q  <= fetch_pc_d;
            instruc_q   <= instruc_d;
            pc_out_q    <= pc_out_d;
            valid_q     <= valid_d;
            hold_q      <= hold_d;
        end
    end

    assign imem_addr   = imem_addr_q;
    assign instruc     = instruc_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = valid_q;

`ifdef STALL_COUNT_EN
    // Count only cycles where the pipe is genuinely held: FILL ignores
    // stall, and a simultaneous flush overrides it.
    logic stall_cnt_en;
    assign stall_cnt_en = ((state_q == FETCH_RUN) || (state_q == FETCH_STALL))
                          && stall && !branch_taken;

    sat_counter #(
        .W (16)
    ) u_stall_cnt (
        .clk_i   (clock),
        .rst_i   (reset),
        .en_i    (stall_cnt_en),
        .count_o (stall_count)
    );
`else
    assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

`ifdef STALL_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [15:0] NOP = 16'h0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [7:0]  imem_addr;
    logic [0:15] imem_data;
    logic [0:15] instruc;
    logic [7:0]  pc_out;
    logic        instr_valid;
    logic [15:0] stall_count;

    fetch_stage #(
        .ADDR_W    (8),
        .RESET_PC  (8'h00),
        .NOP_INSTR (16'h0000)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .instruc       (instruc),
        .pc_out        (pc_out),
        .instr_valid   (instr_valid),
        .stall_count   (stall_count)
    );

    always #5 clock = ~clock;

    // Synchronous-read BRAM whose word at each address equals the address.
    always @(posedge clock) imem_data <= {8'h00, imem_addr};

    typedef struct packed {
        logic        vld;
        logic [7:0]  pc;
        logic [15:0] instr;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   active = 1'b0;

    // Reference model: program order plus bubble budget.
    logic [7:0]  m_next;
    int          m_bub;
    logic        m_vld;
    logic [7:0]  m_pc;
    logic [15:0] m_instr;
    logic [15:0] m_cnt;

    task automatic chk(string nm, int unsigned act, int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_next  = 8'h00;
        m_bub   = 1;
        m_vld   = 1'b0;
        m_pc    = 8'h00;
        m_instr = NOP;
        m_cnt   = 16'h0000;
    endtask

    task automatic apply(bit s, bit b, logic [7:0] t);
        exp_t e;
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        if (b) begin
            m_vld   = 1'b0;
            m_instr = NOP;
            m_bub   = 1;
            m_next  = t;
        end else if (m_bub > 0) begin
            m_vld   = 1'b0;
            m_instr = NOP;
            m_bub   = m_bub - 1;
        end else if (s) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else begin
            m_vld   = 1'b1;
            m_pc    = m_next;
            m_instr = {8'h00, m_next};
            m_next  = m_next + 8'd1;
        end
        e.vld   = m_vld;
        e.pc    = m_pc;
        e.instr = m_instr;
        e.cnt   = CNT_EN ? m_cnt : 16'h0000;
        q.push_back(e);
    endtask

    task automatic step(bit s, bit b, logic [7:0] t);
        @(negedge clock);
        apply(s, b, t);
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        active = 1'b1;
        apply(1'b0, 1'b0, 8'h00);
    endtask

    task automatic check_reset_values(string tag);
        chk({tag, "_imem_addr"},   imem_addr,   8'h00);
        chk({tag, "_instruc"},     instruc,     NOP);
        chk({tag, "_pc_out"},      pc_out,      8'h00);
        chk({tag, "_instr_valid"}, instr_valid, 1'b0);
        chk({tag, "_stall_count"}, stall_count, 16'h0000);
    endtask

    task automatic run_until_pc(logic [7:0] pc);
        int n = 0;
        while (!(m_vld && m_pc == pc) && n < 600) begin
            step(1'b0, 1'b0, 8'h00);
            n++;
        end
        if (n >= 600) begin
            errors++;
            $display("FAIL run_until_pc never reached pc=%0h", pc);
        end
    endtask

    // Monitor: compares the IF/ID outputs against the scoreboard every cycle.
    always @(posedge clock) begin
        exp_t e;
        #2;
        if (active) begin
            if (q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty at t=%0t", $time);
            end else begin
                e = q.pop_front();
                chk("instr_valid", instr_valid, e.vld);
                if (e.vld) begin
                    chk("pc_out",  pc_out,  e.pc);
                    chk("instruc", instruc, e.instr);
                end else begin
                    chk("bubble_instruc", instruc, NOP);
                end
                chk("stall_count", stall_count, e.cnt);
            end
        end
    end

    initial begin
        reset         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 8'h00;
        model_reset();
        #3;
        check_reset_values("por");
        repeat (2) @(posedge clock);
        #2;
        check_reset_values("por_held");

        release_reset();
        repeat (10) step(1'b0, 1'b0, 8'h00);

        // Stall three cycles while instruction 5 sits in IF/ID.
        run_until_pc(8'h05);
        repeat (3) step(1'b1, 1'b0, 8'h00);
        repeat (4) step(1'b0, 1'b0, 8'h00);

        // Taken branch while pc_out = 10.
        run_until_pc(8'h0A);
        step(1'b0, 1'b1, 8'h40);
        repeat (5) step(1'b0, 1'b0, 8'h00);

        // Stall and branch together: flush wins.
        step(1'b1, 1'b1, 8'h20);
        step(1'b1, 1'b0, 8'h00);
        repeat (4) step(1'b0, 1'b0, 8'h00);

        // Address wrap.
        step(1'b0, 1'b1, 8'hFE);
        repeat (6) step(1'b0, 1'b0, 8'h00);

        // Random mix of stalls and branches.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) == 0, ($urandom % 20) == 0, 8'($urandom));
        end

        // Asynchronous reset in the middle of a stall.
        repeat (3) step(1'b0, 1'b0, 8'h00);
        repeat (2) step(1'b1, 1'b0, 8'h00);
        @(posedge clock);
        #4;
        active = 1'b0;
        reset  = 1'b1;
        #1;
        check_reset_values("mid_stall");
        q.delete();
        stall = 1'b0;
        repeat (2) @(posedge clock);
        release_reset();
        repeat (6) step(1'b0, 1'b0, 8'h00);

`ifdef STALL_COUNT_EN
        // Long stall to drive the counter into saturation.
        repeat (70000) step(1'b1, 1'b0, 8'h00);
        repeat (3) step(1'b0, 1'b0, 8'h00);
        repeat (2) step(1'b1, 1'b0, 8'h00);
`endif

        repeat (2) step(1'b0, 1'b0, 8'h00);
        @(posedge clock);
        #3;
        active = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
